rom_dl_sched: RTL and testbench

- Schedules ROM-download bytes from data_io into the two SDRAM write ports. Main and sound code go to port1; sprite data goes to port2, remapped into 32-bit words.
- Uses the toggle req/ack handshake and never issues a new request before the previous one is acknowledged.
- Buffers bursts in a small FIFO.
- Owns rom_loaded and core reset generation, including the delayed second reset pulse.

---
 rtl/rom_dl_pkg.sv | 45 ++++
 rtl/dl_fifo.sv | 61 ++++++
 rtl/rom_dl_sched.sv | 180 ++++++++++++++++++
 tb/tb_rom_dl_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
`default_nettype none
// ============================================================================
//  rom_dl_pkg
//  Shared types and constants for the ROM-download scheduler: the FIFO entry
//  layout, the dispatch state encoding, the default sprite-region bounds and
//  a helper that classifies a download address into its destination port.
//  Revision: 1.0
// ============================================================================
package rom_dl_pkg;

  localparam int          ADDR_W      = 25;
  localparam int          DATA_W      = 8;
  localparam logic [24:0] SP_BASE_DEF = 25'h14000;
  localparam logic [24:0] SP_END_DEF  = 25'h24000;

  // One captured download byte together with its byte address.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dl_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2
  } disp_state_t;

  typedef enum logic [1:0] {
    REG_PORT1 = 2'd0,
    REG_PORT2 = 2'd1,
    REG_NONE  = 2'd2
  } region_t;

  // Code below the sprite base goes to port1, the sprite window to port2,
  // and anything past the window is not backed by SDRAM and is discarded.
  function automatic region_t classify(input logic [24:0] addr,
                                       input logic [24:0] sp_base,
                                       input logic [24:0] sp_end);
    if (addr < sp_base)     return REG_PORT1;
    else if (addr < sp_end) return REG_PORT2;
    else                    return REG_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dl_fifo.sv
`default_nettype none
// ============================================================================
//  dl_fifo
//  Synchronous FIFO of download entries with full/empty flags. A push while
//  full is accepted when a pop happens on the same edge.
//  Ports:
//    clk, rst_n      clock, asynchronous active-low reset
//    push, push_data write request and entry
//    pop             read request (head advances on the edge)
//    pop_data        current head entry (valid when !empty)
//    full, empty     occupancy flags
//  Revision: 1.0
// ============================================================================
module dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  dl_entry_t push_data,
  input  logic      pop,
  output dl_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  dl_entry_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/rom_dl_sched.sv
`default_nettype none
// ============================================================================
//  rom_dl_sched
//  Moves ROM-download bytes into the two SDRAM write ports using a toggle
//  req/ack handshake, buffering strobes in a small FIFO. Also owns the
//  rom_loaded flag and core reset generation (including a delayed second
//  one-cycle reset pulse after release).
//  Ports:
//    clk_sys, reset_n                 clock, asynchronous active-low reset
//    ioctl_download/wr/addr/dout      download byte stream
//    ext_reset                        external core reset request
//    port1_*                          main/sound code write port
//    port2_*                          sprite write port (remapped words)
//    rom_loaded                       download finished and drained
//    core_reset                       active-high core reset
//    overflow                         sticky, a byte was lost on full FIFO
//    dropped_cnt                      saturating count of out-of-region bytes
//  Revision: 1.0
// ============================================================================
module rom_dl_sched
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
  parameter logic [24:0] SP_END     = SP_END_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [15:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow,
  output logic [7:0]  dropped_cnt
);

  logic        wr_last;
  logic        dl_last;
  logic        capture;
  logic        dl_rise;
  logic        pop;
  logic        drained;
  logic        fifo_full;
  logic        fifo_empty;
  dl_entry_t   push_entry;
  dl_entry_t   head;
  disp_state_t state;
  region_t     region;
  logic [16:0] sa;
  logic [15:0] cnt;

  // Each strobe may last several cycles; only its rising edge is a byte.
  assign capture    = ioctl_download & ioctl_wr & ~wr_last;
  assign dl_rise    = ioctl_download & ~dl_last;
  assign pop        = (state == ST_IDLE) & ~fifo_empty;
  assign drained    = ~ioctl_download & fifo_empty & (state == ST_IDLE);
  assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};
  assign region     = classify(head.addr, SP_BASE, SP_END);
  // Only the low 17 bits of the sprite offset feed the word remap.
  assign sa         = 17'(head.addr - SP_BASE);

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .push      (capture),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Edge detectors, overflow flag, write enables and rom_loaded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_last    <= 1'b0;
      dl_last    <= 1'b0;
      overflow   <= 1'b0;
      port1_we   <= 1'b0;
      port2_we   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_last <= ioctl_wr;
      dl_last <= ioctl_download;
      if (dl_rise) overflow <= 1'b0;
      // A drop on the very edge a new download starts must still be seen.
      if (capture & fifo_full & ~pop) overflow <= 1'b1;
      if (dl_rise) begin
        port1_we   <= 1'b1;
        port2_we   <= 1'b1;
        rom_loaded <= 1'b0;
      end else if (drained & port1_we) begin
        // port1_we doubles as "a download is being finished".
        port1_we   <= 1'b0;
        port2_we   <= 1'b0;
        rom_loaded <= 1'b1;
      end
    end
  end

  // Dispatch FSM: one outstanding request at a time across both ports.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      port1_req   <= 1'b0;
      port1_a     <= '0;
      port1_ds    <= '0;
      port1_d     <= '0;
      port2_req   <= 1'b0;
      port2_a     <= '0;
      port2_ds    <= '0;
      port2_d     <= '0;
      dropped_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            case (region)
              REG_PORT1: begin
                port1_a   <= head.addr[23:1];
                port1_ds  <= {head.addr[0], ~head.addr[0]};
                port1_d   <= {head.data, head.data};
                port1_req <= ~port1_req;
                state     <= ST_WAIT1;
              end
              REG_PORT2: begin
                // Sprite planes are interleaved: bit 16 of the offset
                // becomes the word LSB and bit 15 selects the byte lane.
                port2_a   <= {sa[14:0], sa[16]};
                port2_ds  <= {sa[15], ~sa[15]};
                port2_d   <= {head.data, head.data};
                port2_req <= ~port2_req;
                state     <= ST_WAIT2;
              end
              default: begin
                if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
              end
            endcase
          end
        end
        ST_WAIT1: if (port1_ack == port1_req) state <= ST_IDLE;
        ST_WAIT2: if (port2_ack == port2_req) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Core reset: held while not loaded or externally requested, then a second
  // one-cycle pulse when the hold counter passes 1.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= RESET_HOLD;
      core_reset <= 1'b1;
    end else begin
      if (ext_reset | ~rom_loaded) cnt <= RESET_HOLD;
      else if (cnt != 16'd0)       cnt <= cnt - 16'd1;
      core_reset <= ext_reset | ~rom_loaded | (cnt == 16'd1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sched.sv
`default_nettype none
// ============================================================================
//  tb_rom_dl_sched
//  Directed bench for rom_dl_sched. Expected port writes are queued when a
//  byte is sent; a monitor pops and compares on every req toggle.
//  Revision: 1.0
// ============================================================================
module tb_rom_dl_sched;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ext_reset;
  logic        port1_req, port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port1_we;
  logic        port2_req, port2_ack;
  logic [15:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        port2_we;
  logic        rom_loaded, core_reset, overflow;
  logic [7:0]  dropped_cnt;

  always #5 clk_sys = ~clk_sys;

  rom_dl_sched #(
    .SP_BASE    (25'h14000),
    .SP_END     (25'h24000),
    .FIFO_DEPTH (4),
    .RESET_HOLD (16'd16)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ext_reset      (ext_reset),
    .port1_req      (port1_req),
    .port1_ack      (port1_ack),
    .port1_a        (port1_a),
    .port1_ds       (port1_ds),
    .port1_d        (port1_d),
    .port1_we       (port1_we),
    .port2_req      (port2_req),
    .port2_ack      (port2_ack),
    .port2_a        (port2_a),
    .port2_ds       (port2_ds),
    .port2_d        (port2_d),
    .port2_we       (port2_we),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .overflow       (overflow),
    .dropped_cnt    (dropped_cnt)
  );

  typedef struct packed {logic [22:0] a; logic [1:0] ds; logic [15:0] d;} p1_t;
  typedef struct packed {logic [15:0] a; logic [1:0] ds; logic [15:0] d;} p2_t;

  p1_t  q1[$];
  p2_t  q2[$];
  p1_t  e1;
  p2_t  e2;
  int   n_vec = 0;
  int   n_err = 0;
  int   p1_cnt = 0;
  int   p2_cnt = 0;
  logic p1_prev = 1'b0;
  logic p2_prev = 1'b0;
  logic hold1 = 1'b0;
  logic hold2 = 1'b0;

  // SDRAM side: acks one cycle after a toggle unless held; shares reset_n.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port1_ack <= 1'b0;
      port2_ack <= 1'b0;
    end else begin
      if (!hold1) port1_ack <= port1_req;
      if (!hold2) port2_ack <= port2_req;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every req toggle is one write, compared against the queue head.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (port1_req !== p1_prev) begin
        p1_cnt++;
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL port1_unexpected a=%h ds=%b d=%h required none", port1_a, port1_ds, port1_d);
        end else begin
          e1 = q1.pop_front();
          chk("port1_write", {port1_a, port1_ds, port1_d}, e1);
        end
      end
      if (port2_req !== p2_prev) begin
        p2_cnt++;
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL port2_unexpected a=%h ds=%b d=%h required none", port2_a, port2_ds, port2_d);
        end else begin
          e2 = q2.pop_front();
          chk("port2_write", {port2_a, port2_ds, port2_d}, e2);
        end
      end
    end
    p1_prev = port1_req;
    p2_prev = port2_req;
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (2) @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k = 0;
    while ((q1.size() != 0 || q2.size() != 0) && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    n_vec++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL %s pending p1=%0d p2=%0d required 0", name, q1.size(), q2.size());
    end
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c2, k, hi_cnt, hi_pos;
    logic first_after;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ext_reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_req", {port1_req, port2_req}, 2'b00);
    chk("rst_we", {port1_we, port2_we}, 2'b00);
    chk("rst_p1", {port1_a, port1_ds, port1_d}, '0);
    chk("rst_p2", {port2_a, port2_ds, port2_d}, '0);
    chk("rst_flags", {rom_loaded, core_reset, overflow}, 3'b010);
    chk("rst_dropped", dropped_cnt, 8'd0);
    reset_n = 1'b1;

    // Four port1 bytes.
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("we_set", {port1_we, port2_we}, 2'b11);
    q1.push_back('{23'h0, 2'b01, 16'hAAAA}); send_byte(25'h00000, 8'hAA);
    q1.push_back('{23'h0, 2'b10, 16'hBBBB}); send_byte(25'h00001, 8'hBB);
    q1.push_back('{23'h1, 2'b01, 16'hCCCC}); send_byte(25'h00002, 8'hCC);
    q1.push_back('{23'h1, 2'b10, 16'hDDDD}); send_byte(25'h00003, 8'hDD);
    wait_empty("p1_drain", 50);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("p1_count", p1_cnt, 4);
    chk("p2_untouched", p2_cnt, 0);
    chk("loaded_1", rom_loaded, 1'b1);
    chk("we_clear", {port1_we, port2_we}, 2'b00);

    // Sprite region, boundaries and out-of-region bytes.
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("loaded_clr", rom_loaded, 1'b0);
    q2.push_back('{16'h0000, 2'b01, 16'h5555}); send_byte(25'h14000, 8'h55);
    q2.push_back('{16'h0000, 2'b10, 16'h6666}); send_byte(25'h1C000, 8'h66);
    q2.push_back('{16'hFFFE, 2'b10, 16'h7777}); send_byte(25'h23FFF, 8'h77);
    q1.push_back('{23'h09FFF, 2'b10, 16'h1111}); send_byte(25'h13FFF, 8'h11);
    wait_empty("p2_drain", 50);
    c0 = p1_cnt + p2_cnt;
    send_byte(25'h30000, 8'hEE);
    repeat (2) @(negedge clk_sys);
    chk("drop_1", dropped_cnt, 8'd1);
    send_byte(25'h24000, 8'hEF);
    repeat (2) @(negedge clk_sys);
    chk("drop_2", dropped_cnt, 8'd2);
    chk("drop_no_req", p1_cnt + p2_cnt - c0, 0);
    chk("p2_count", p2_cnt, 3);

    // Overflow: ack held while six strobes arrive.
    c0 = p1_cnt;
    hold1 = 1'b1;
    q1.push_back('{23'h80, 2'b01, 16'h0101});
    q1.push_back('{23'h80, 2'b10, 16'h0202});
    q1.push_back('{23'h81, 2'b01, 16'h0303});
    q1.push_back('{23'h81, 2'b10, 16'h0404});
    q1.push_back('{23'h82, 2'b01, 16'h0505});
    for (int i = 0; i < 6; i++) send_byte(25'h100 + 25'(i), 8'(i + 1));
    repeat (2) @(negedge clk_sys);
    chk("ovf_one_req", p1_cnt - c0, 1);
    chk("ovf_flag", overflow, 1'b1);
    hold1 = 1'b0;
    wait_empty("ovf_drain", 60);
    chk("ovf_five", p1_cnt - c0, 5);
    chk("ovf_sticky", overflow, 1'b1);

    // Download falls while waiting for an ack.
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("ovf_cleared", overflow, 1'b0);
    hold1 = 1'b1;
    c0 = p1_cnt;
    q1.push_back('{23'h100, 2'b01, 16'h0A0A}); send_byte(25'h200, 8'h0A);
    chk("wait1_req", p1_cnt - c0, 1);
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("loaded_wait_ack", rom_loaded, 1'b0);
    chk("core_rst_held", core_reset, 1'b1);
    hold1 = 1'b0;
    k = 0;
    while (!rom_loaded && k < 10) begin @(negedge clk_sys); k++; end
    chk("loaded_after_ack", rom_loaded, 1'b1);
    chk("core_rst_same_cyc", core_reset, 1'b1);
    hi_cnt = 0; hi_pos = 0; first_after = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_sys);
      if (j == 1) first_after = core_reset;
      if (core_reset) begin
        hi_cnt++;
        if (hi_pos == 0) hi_pos = j;
      end
    end
    chk("core_rst_release", first_after, 1'b0);
    chk("pulse_count", hi_cnt, 1);
    chk("pulse_pos", hi_pos, 16);
    ext_reset = 1'b1;
    @(negedge clk_sys);
    chk("ext_reset_on", core_reset, 1'b1);
    ext_reset = 1'b0;
    @(negedge clk_sys);
    chk("ext_reset_off", core_reset, 1'b0);

    // Asynchronous reset during WAIT2 with a byte still queued.
    ioctl_download = 1'b1;
    hold2 = 1'b1;
    c2 = p2_cnt;
    q2.push_back('{16'h0004, 2'b01, 16'h3C3C}); send_byte(25'h14002, 8'h3C);
    send_byte(25'h00000, 8'h99);
    chk("wait2_req", p2_cnt - c2, 1);
    @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("arst_p2", {port2_a, port2_ds, port2_d}, '0);
    chk("arst_req", {port1_req, port2_req}, 2'b00);
    chk("arst_we", {port1_we, port2_we}, 2'b00);
    chk("arst_flags", {rom_loaded, core_reset, overflow}, 3'b010);
    chk("arst_dropped", dropped_cnt, 8'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    hold2 = 1'b0;
    repeat (5) @(negedge clk_sys);
    // The stale 0x99 byte must be gone: the next write is the new byte.
    ioctl_download = 1'b1;
    q1.push_back('{23'h10, 2'b01, 16'h4242}); send_byte(25'h20, 8'h42);
    wait_empty("post_rst_drain", 50);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("post_rst_loaded", rom_loaded, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
